rvi_bits_op_issue: RTL and testbench
====================================

Name: rvi_bits_op_issue

Overview:
Issue-side driver for the RV32I/RV64I bitwise execution unit. It accepts register-read instructions over a valid/ready channel and decodes AND/OR/XOR/ANDI/ORI/XORI. It drives the exec unit's s1/s2/andEn/orEn/xorEn inputs from a pipeline register and captures the unit's rslt into a writeback register. It sits between register-file read and writeback, with two pipeline stages (E, W) and full-throughput backpressure.

Parameters:
RV64, 0, 1 selects 64-bit datapath.
CPU_WIDTH, 32*(RV64+1), derived datapath width; not overridden.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills both stages this cycle
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid&&in_ready
in_instr  in  32  raw instruction word
in_rs1  in  CPU_WIDTH  rs1 register value
in_rs2  in  CPU_WIDTH  rs2 register value
bits_s1  out  CPU_WIDTH  to exec unit s1
bits_s2  out  CPU_WIDTH  to exec unit s2
bits_and_en  out  1  to exec unit andEn
bits_or_en  out  1  to exec unit orEn
bits_xor_en  out  1  to exec unit xorEn
bits_rslt  in  CPU_WIDTH  combinational result from exec unit
wb_valid  out  1  writeback entry valid
wb_ready  in  1  consumer accepts when wb_valid&&wb_ready
wb_rd  out  5  destination register
wb_data  out  CPU_WIDTH  result
wb_illegal  out  1  instruction not decodable by this block

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous and active-low. While rst_n is low, all state clears: e_vld=0, w_vld=0, all E/W payload=0. Outputs reset to in_ready=1, wb_valid=0, wb_rd=0, wb_data=0, wb_illegal=0, bits_*=0.
- Decode (combinational, on input):
  - Opcode 0110011 with funct7=0000000 is R-type. The s2 operand is in_rs2.
  - Opcode 0010011 is I-type. The s2 operand is sign-extended instr[31:20] to CPU_WIDTH.
  - funct3 111 selects AND, 110 selects OR, 100 selects XOR.
  - Anything else is illegal: en=000, illegal=1.
- Stage E register: e_vld, e_rd, e_s1, e_s2, e_en[2:0], e_ill.
  - bits_s1/bits_s2 = e_s1/e_s2.
  - bits_*_en = e_en & {3{e_vld}}. At most one enable is high; all are 0 when E is empty or illegal.
- Stage W register: w_vld, w_rd, w_data, w_ill.
  - On transfer E→W, w_data is captured as follows:
    - bits_rslt when the instruction is legal and e_rd≠0.
    - 0 when e_rd=0 or illegal.
  - w_ill takes e_ill.
- Handshake:
  - w_free = !w_vld || wb_ready.
  - e_adv = e_vld && w_free.
  - in_ready = !e_vld || w_free. Combinational; depends on wb_ready only, never on in_valid.
  - E loads on in_valid&&in_ready.
  - E clears when e_adv occurs with no new load.
  - W loads on e_adv. W clears on wb handshake with no e_adv.
- Latency: 2 cycles from input handshake to wb_valid, with wb_ready held high. Sustains 1 instr/cycle.
- Backpressure:
  - wb_ready=0 with both stages full gives in_ready=0.
  - E and W payloads stay stable while held. bits_* therefore stay stable too.
  - Data is never dropped or duplicated.
- Simultaneous events:
  - Load into E and E→W in the same cycle is a legal pass-through.
  - W drain and W refill in the same cycle is legal.
- flush: next edge, e_vld=0 and w_vld=0, and the current input handshake is discarded. flush has priority over all loads. in_ready is not gated by flush.
- Reset mid-operation: in-flight entries are lost with no wb_valid pulse. The first post-reset accept behaves exactly as from idle.
- Width rules: RV64=0 uses 32-bit immediate sign extension. RV64=1 sign-extends bit 31 of the immediate field through bit 63.

Decomposition:
- Package rvi_bits_pkg holds:
  - opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011;
  - funct3 constants F3_AND/F3_OR/F3_XOR;
  - a bits_op_e enum {AND, OR, XOR, NONE};
  - a decode result struct {en[2:0], imm_sel, illegal, rd}.
- One sub-module: rvi_bits_decode (combinational instr → decode struct, parameterised by RV64).
- The top holds the E/W registers and handshake.

Test Plan:
- AND x3,x1,x2 (0x0020F1B3), rs1=0xF0F0F0F0, rs2=0x0FF00FF0, wb_ready=1 → bits_and_en=1 in cycle 1; wb_valid in cycle 2 with wb_rd=3, wb_data=0x00F000F0, wb_illegal=0.
- XORI x5,x6,-1 (0xFFF34293), rs1=0x12345678 → bits_s2=0xFFFFFFFF, bits_xor_en=1; wb_data=0xEDCBA987. With RV64=1 and rs1=0x12345678: bits_s2=all ones, wb_data=0xFFFFFFFFEDCBA987.
- SUB (0x40208033) → bits enables all 0; wb_valid with wb_illegal=1, wb_data=0.
- Back-to-back ORI stream of 4 with wb_ready low for 3 cycles after the second instr:
  - in_ready drops once E and W are full;
  - the 4 results emerge in order, none lost or duplicated;
  - bits_* are stable while stalled.
- Pipeline full, then flush=1 for one cycle → wb_valid=0 next cycle. The next accepted instr appears 2 cycles later.
- rst_n asserted low asynchronously mid-stream → wb_valid, bits_*_en drop immediately; in_ready=1 after release.

Source files
------------

// File: rtl/rvi_bits_pkg.sv
// Shared decode constants, op enum and decode result type for the bitwise-op issue block.
package rvi_bits_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;

  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_XOR = 3'b100;

  // Bit positions inside the 3-bit enable vector
  localparam int EN_AND = 0;
  localparam int EN_OR  = 1;
  localparam int EN_XOR = 2;

  typedef enum logic [1:0] {
    AND  = 2'd0,
    OR   = 2'd1,
    XOR  = 2'd2,
    NONE = 2'd3
  } bits_op_e;

  typedef struct packed {
    logic [2:0] en;
    logic       imm_sel;
    logic       illegal;
    logic [4:0] rd;
  } bits_dec_t;

  function automatic logic [2:0] op_to_en(input bits_op_e op);
    logic [2:0] en;
    case (op)
      AND:     en = 3'b001;
      OR:      en = 3'b010;
      XOR:     en = 3'b100;
      default: en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/rvi_bits_op_issue_if.sv
// Issue-side channel: instruction input, exec-unit drive/return, and writeback output.
interface rvi_bits_op_issue_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [CPU_WIDTH-1:0] in_rs1;
  logic [CPU_WIDTH-1:0] in_rs2;
  logic [CPU_WIDTH-1:0] bits_s1;
  logic [CPU_WIDTH-1:0] bits_s2;
  logic                 bits_and_en;
  logic                 bits_or_en;
  logic                 bits_xor_en;
  logic [CPU_WIDTH-1:0] bits_rslt;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [4:0]           wb_rd;
  logic [CPU_WIDTH-1:0] wb_data;
  logic                 wb_illegal;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, bits_rslt, wb_ready,
    input  in_ready, bits_s1, bits_s2, bits_and_en, bits_or_en, bits_xor_en,
           wb_valid, wb_rd, wb_data, wb_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, bits_rslt, wb_ready,
    output in_ready, bits_s1, bits_s2, bits_and_en, bits_or_en, bits_xor_en,
           wb_valid, wb_rd, wb_data, wb_illegal
  );
endinterface

// File: rtl/rvi_bits_decode.sv
// Combinational decode of AND/OR/XOR(I) into exec-unit enables, operand select and legality.
module rvi_bits_decode
  import rvi_bits_pkg::*;
#(
  parameter int RV64 = 0
) (
  input  logic [31:0]            instr,
  output bits_dec_t              dec,
  output logic [32*(RV64+1)-1:0] imm
);

  localparam int CPU_WIDTH = 32 * (RV64 + 1);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  bits_op_e   op_s;
  logic       fmt_ok_s;
  logic       imm_sel_s;
  logic       rs1_field_unused_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];

  // rs1 index is resolved upstream; the value arrives on in_rs1
  assign rs1_field_unused_s = ^instr[19:15];

  // Instruction format: R-type needs a zero funct7, I-type takes the immediate
  always_comb begin
    fmt_ok_s  = 1'b0;
    imm_sel_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        fmt_ok_s  = (funct7_s == F7_BASE);
        imm_sel_s = 1'b0;
      end
      OPC_OPIMM: begin
        fmt_ok_s  = 1'b1;
        imm_sel_s = 1'b1;
      end
      default: begin
        fmt_ok_s  = 1'b0;
        imm_sel_s = 1'b0;
      end
    endcase
  end

  // Operation from funct3
  always_comb begin
    op_s = NONE;
    case (funct3_s)
      F3_AND:  op_s = AND;
      F3_OR:   op_s = OR;
      F3_XOR:  op_s = XOR;
      default: op_s = NONE;
    endcase
  end

  // Assemble decode result; illegal encodings never raise an enable
  always_comb begin
    dec         = '0;
    dec.rd      = instr[11:7];
    dec.imm_sel = imm_sel_s;
    if (fmt_ok_s && (op_s != NONE)) begin
      dec.en      = op_to_en(op_s);
      dec.illegal = 1'b0;
    end else begin
      dec.en      = 3'b000;
      dec.illegal = 1'b1;
    end
  end

  assign imm = {{(CPU_WIDTH-12){instr[31]}}, instr[31:20]};

endmodule

// File: rtl/rvi_bits_op_issue.sv
// Two-stage (E, W) issue/writeback pipeline around the bitwise exec unit with
// full-throughput valid/ready backpressure and a synchronous flush.
module rvi_bits_op_issue
  import rvi_bits_pkg::*;
#(
  parameter int RV64 = 0
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  rvi_bits_op_issue_if.slave bus
);

  localparam int CPU_WIDTH = 32 * (RV64 + 1);

  bits_dec_t            dec_s;
  logic [CPU_WIDTH-1:0] imm_s;
  logic [CPU_WIDTH-1:0] s2_sel_s;
  logic [CPU_WIDTH-1:0] w_data_nxt_s;
  logic                 w_free_s;
  logic                 e_adv_s;
  logic                 in_ready_s;
  logic                 load_s;

  logic                 e_vld_r;
  logic [4:0]           e_rd_r;
  logic [CPU_WIDTH-1:0] e_s1_r;
  logic [CPU_WIDTH-1:0] e_s2_r;
  logic [2:0]           e_en_r;
  logic                 e_ill_r;

  logic                 w_vld_r;
  logic [4:0]           w_rd_r;
  logic [CPU_WIDTH-1:0] w_data_r;
  logic                 w_ill_r;

  rvi_bits_decode #(
    .RV64 (RV64)
  ) u_decode (
    .instr (bus.in_instr),
    .dec   (dec_s),
    .imm   (imm_s)
  );

  // Handshake: in_ready looks only at pipeline state and wb_ready
  always_comb begin
    w_free_s   = !w_vld_r || bus.wb_ready;
    e_adv_s    = e_vld_r && w_free_s;
    in_ready_s = !e_vld_r || w_free_s;
    load_s     = bus.in_valid && in_ready_s;
  end

  // Operand select and writeback data; x0 and illegal ops write back zero
  always_comb begin
    if (dec_s.imm_sel) begin
      s2_sel_s = imm_s;
    end else begin
      s2_sel_s = bus.in_rs2;
    end
    if (!e_ill_r && (e_rd_r != 5'd0)) begin
      w_data_nxt_s = bus.bits_rslt;
    end else begin
      w_data_nxt_s = '0;
    end
  end

  // Stage E: flush wins over any load; payload holds while E waits on W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld_r <= 1'b0;
      e_rd_r  <= 5'd0;
      e_s1_r  <= '0;
      e_s2_r  <= '0;
      e_en_r  <= 3'b000;
      e_ill_r <= 1'b0;
    end else if (flush) begin
      e_vld_r <= 1'b0;
    end else if (load_s) begin
      e_vld_r <= 1'b1;
      e_rd_r  <= dec_s.rd;
      e_s1_r  <= bus.in_rs1;
      e_s2_r  <= s2_sel_s;
      e_en_r  <= dec_s.en;
      e_ill_r <= dec_s.illegal;
    end else if (e_adv_s) begin
      e_vld_r <= 1'b0;
    end
  end

  // Stage W: refills on E advance, empties on a writeback handshake otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_vld_r  <= 1'b0;
      w_rd_r   <= 5'd0;
      w_data_r <= '0;
      w_ill_r  <= 1'b0;
    end else if (flush) begin
      w_vld_r <= 1'b0;
    end else if (e_adv_s) begin
      w_vld_r  <= 1'b1;
      w_rd_r   <= e_rd_r;
      w_data_r <= w_data_nxt_s;
      w_ill_r  <= e_ill_r;
    end else if (w_vld_r && bus.wb_ready) begin
      w_vld_r <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.bits_s1     = e_s1_r;
  assign bus.bits_s2     = e_s2_r;
  assign bus.bits_and_en = e_vld_r & e_en_r[EN_AND];
  assign bus.bits_or_en  = e_vld_r & e_en_r[EN_OR];
  assign bus.bits_xor_en = e_vld_r & e_en_r[EN_XOR];
  assign bus.wb_valid    = w_vld_r;
  assign bus.wb_rd       = w_rd_r;
  assign bus.wb_data     = w_data_r;
  assign bus.wb_illegal  = w_ill_r;

endmodule

// File: tb/tb_rvi_bits_op_issue.sv
// Drives a 32-bit and a 64-bit instance with identical stimulus and compares both
// against an in-order queue model of the two-stage pipeline.
module tb_rvi_bits_op_issue;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        flush    = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [63:0] rs1      = 64'h0;
  logic [63:0] rs2      = 64'h0;
  logic        wb_ready = 1'b1;
  int          errors   = 0;
  int          checks   = 0;
  logic        last_acc = 1'b0;

  always #5 clk = ~clk;

  rvi_bits_op_issue_if #(.CPU_WIDTH(32)) bus32 ();
  rvi_bits_op_issue_if #(.CPU_WIDTH(64)) bus64 ();

  assign bus32.in_valid = in_valid;
  assign bus32.in_instr = in_instr;
  assign bus32.in_rs1   = rs1[31:0];
  assign bus32.in_rs2   = rs2[31:0];
  assign bus32.wb_ready = wb_ready;
  assign bus64.in_valid = in_valid;
  assign bus64.in_instr = in_instr;
  assign bus64.in_rs1   = rs1;
  assign bus64.in_rs2   = rs2;
  assign bus64.wb_ready = wb_ready;

  // Exec unit stand-in
  assign bus32.bits_rslt = ({32{bus32.bits_and_en}} & (bus32.bits_s1 & bus32.bits_s2)) |
                           ({32{bus32.bits_or_en}}  & (bus32.bits_s1 | bus32.bits_s2)) |
                           ({32{bus32.bits_xor_en}} & (bus32.bits_s1 ^ bus32.bits_s2));
  assign bus64.bits_rslt = ({64{bus64.bits_and_en}} & (bus64.bits_s1 & bus64.bits_s2)) |
                           ({64{bus64.bits_or_en}}  & (bus64.bits_s1 | bus64.bits_s2)) |
                           ({64{bus64.bits_xor_en}} & (bus64.bits_s1 ^ bus64.bits_s2));

  rvi_bits_op_issue #(.RV64(0)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave));
  rvi_bits_op_issue #(.RV64(1)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave));

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] s1;
    logic [63:0] s2_32;
    logic [63:0] s2_64;
    logic [2:0]  en;
    logic        ill;
    logic [63:0] d32;
    logic [63:0] d64;
    int          age;
  } ent_t;

  // Oldest first; age = edges since acceptance (0 means still in E)
  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t make_entry(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
    ent_t e;
    logic r_ok, i_ok;
    logic [63:0] res;
    r_ok = (ins[6:0] == 7'h33) && (ins[31:25] == 7'h00);
    i_ok = (ins[6:0] == 7'h13);
    e.rd    = ins[11:7];
    e.s1    = a;
    e.age   = 0;
    e.s2_64 = i_ok ? {{52{ins[31]}}, ins[31:20]} : b;
    e.s2_32 = {32'h0, e.s2_64[31:0]};
    case (ins[14:12])
      3'b111:  begin e.en = 3'b001; res = a & e.s2_64; end
      3'b110:  begin e.en = 3'b010; res = a | e.s2_64; end
      3'b100:  begin e.en = 3'b100; res = a ^ e.s2_64; end
      default: begin e.en = 3'b000; res = 64'h0; end
    endcase
    e.ill = !(r_ok || i_ok) || (e.en == 3'b000);
    if (e.ill) e.en = 3'b000;
    e.d64 = (e.ill || (e.rd == 5'd0)) ? 64'h0 : res;
    e.d32 = {32'h0, e.d64[31:0]};
    return e;
  endfunction

  function automatic logic exp_ready();
    return (q.size() < 2) || wb_ready;
  endfunction

  function automatic logic exp_wbv();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic int e_idx();
    if ((q.size() > 0) && (q[0].age == 0)) return 0;
    if (q.size() == 2) return 1;
    return -1;
  endfunction

  task automatic check_outputs();
    int ei;
    logic [2:0] exp_en;
    ei = e_idx();
    exp_en = 3'b000;
    if (ei >= 0) exp_en = q[ei].en;
    chk("in_ready32", bus32.in_ready, exp_ready());
    chk("in_ready64", bus64.in_ready, exp_ready());
    chk("wb_valid32", bus32.wb_valid, exp_wbv());
    chk("wb_valid64", bus64.wb_valid, exp_wbv());
    if (exp_wbv()) begin
      chk("wb_rd32", bus32.wb_rd, q[0].rd);
      chk("wb_rd64", bus64.wb_rd, q[0].rd);
      chk("wb_data32", bus32.wb_data, q[0].d32);
      chk("wb_data64", bus64.wb_data, q[0].d64);
      chk("wb_ill32", bus32.wb_illegal, q[0].ill);
      chk("wb_ill64", bus64.wb_illegal, q[0].ill);
    end
    chk("en32", {bus32.bits_xor_en, bus32.bits_or_en, bus32.bits_and_en}, exp_en);
    chk("en64", {bus64.bits_xor_en, bus64.bits_or_en, bus64.bits_and_en}, exp_en);
    if (ei >= 0) begin
      chk("s1_32", bus32.bits_s1, {32'h0, q[ei].s1[31:0]});
      chk("s2_32", bus32.bits_s2, q[ei].s2_32);
      chk("s1_64", bus64.bits_s1, q[ei].s1);
      chk("s2_64", bus64.bits_s2, q[ei].s2_64);
    end
  endtask

  task automatic advance_model();
    logic acc, pop;
    acc = in_valid && exp_ready() && !flush;
    pop = exp_wbv() && wb_ready && !flush;
    last_acc = acc;
    if (flush) begin
      q.delete();
    end else begin
      foreach (q[i]) q[i].age++;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(make_entry(in_instr, rs1, rs2));
    end
  endtask

  // One clock: check at the falling edge, predict, then step past the rising edge
  task automatic tick();
    @(negedge clk);
    check_outputs();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] f3;
    logic [4:0] rd;
    int k;
    k = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0:       f3 = 3'b111;
      1:       f3 = 3'b110;
      default: f3 = 3'b100;
    endcase
    if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    if (k < 4)       return {7'h00, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
    else if (k < 8)  return {12'($urandom), 5'($urandom), f3, rd, 7'h13};
    else if (k == 8) return {7'h20, 5'($urandom), 5'($urandom), f3, rd, 7'h33};
    else             return {25'($urandom), 7'h03};
  endfunction

  initial begin
    int k;
    int c;
    logic saw_stall;

    // Reset state
    #12;
    chk("rst_in_ready", bus32.in_ready, 1'b1);
    chk("rst_wb_valid", {bus32.wb_valid, bus64.wb_valid}, 2'b00);
    chk("rst_wb_rd", bus32.wb_rd, 5'd0);
    chk("rst_wb_data", bus64.wb_data, 64'h0);
    chk("rst_wb_ill", bus32.wb_illegal, 1'b0);
    chk("rst_en", {bus64.bits_xor_en, bus64.bits_or_en, bus64.bits_and_en}, 3'b000);
    chk("rst_s1s2", {bus64.bits_s1, bus32.bits_s2}, 96'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // AND x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h0020F1B3; rs1 = 64'hF0F0F0F0; rs2 = 64'h0FF00FF0;
    tick();
    in_valid = 1'b0;
    chk("and_en_c1", bus32.bits_and_en, 1'b1);
    tick();
    chk("and_wbv_c2", bus32.wb_valid, 1'b1);
    chk("and_rd", bus32.wb_rd, 5'd3);
    chk("and_data", bus32.wb_data, 32'h00F000F0);
    chk("and_ill", bus32.wb_illegal, 1'b0);

    // XORI x5,x6,-1
    in_valid = 1'b1; in_instr = 32'hFFF34293; rs1 = 64'h12345678;
    tick();
    in_valid = 1'b0;
    chk("xori_s2_32", bus32.bits_s2, 32'hFFFFFFFF);
    chk("xori_s2_64", bus64.bits_s2, 64'hFFFFFFFFFFFFFFFF);
    chk("xori_en", bus32.bits_xor_en, 1'b1);
    tick();
    chk("xori_d32", bus32.wb_data, 32'hEDCBA987);
    chk("xori_d64", bus64.wb_data, 64'hFFFFFFFFEDCBA987);

    // SUB is not ours
    in_valid = 1'b1; in_instr = 32'h40208033; rs1 = 64'h55; rs2 = 64'h33;
    tick();
    in_valid = 1'b0;
    chk("sub_en", {bus32.bits_xor_en, bus32.bits_or_en, bus32.bits_and_en}, 3'b000);
    tick();
    chk("sub_wbv", bus32.wb_valid, 1'b1);
    chk("sub_ill", bus32.wb_illegal, 1'b1);
    chk("sub_data", bus64.wb_data, 64'h0);
    tick();

    // Four ORIs, consumer stalls for three cycles after the second
    k = 0; c = 0; saw_stall = 1'b0;
    while (((k < 4) || (q.size() > 0)) && (c < 40)) begin
      wb_ready = !((c >= 2) && (c < 5));
      in_valid = (k < 4);
      in_instr = {12'h8F0 + 12'(k), 5'd1, 3'b110, 5'(k + 1), 7'h13};
      rs1 = {32'h0, 32'hA5A50000 | 32'(k)};
      #1;
      if (!bus32.in_ready) saw_stall = 1'b1;
      tick();
      if (last_acc) k++;
      c++;
    end
    in_valid = 1'b0; wb_ready = 1'b1;
    chk("ori_sent", k, 4);
    chk("ori_stall_seen", saw_stall, 1'b1);
    chk("ori_drained", bus32.wb_valid, 1'b0);

    // Fill both stages, then flush with an offer that must be dropped
    wb_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0020F1B3; rs1 = 64'h1234; rs2 = 64'hFF;
    tick();
    in_instr = 32'h0020E233; rs1 = 64'h1000; rs2 = 64'h0001;
    tick();
    chk("fill_wbv", bus32.wb_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    chk("flush_wbv32", bus32.wb_valid, 1'b0);
    chk("flush_wbv64", bus64.wb_valid, 1'b0);
    chk("flush_en", {bus32.bits_xor_en, bus32.bits_or_en, bus32.bits_and_en}, 3'b000);
    in_valid = 1'b1; in_instr = 32'h0020F1B3; rs1 = 64'hFF00; rs2 = 64'h0FF0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_flush_wbv", bus32.wb_valid, 1'b1);
    chk("post_flush_data", bus32.wb_data, 32'h00000F00);
    tick();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_instr = rand_instr();
      rs1 = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      wb_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tick();
      flush = 1'b0;
    end

    // Asynchronous reset with both stages occupied
    wb_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0020C1B3;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wbv", {bus32.wb_valid, bus64.wb_valid}, 2'b00);
    chk("arst_en32", {bus32.bits_xor_en, bus32.bits_or_en, bus32.bits_and_en}, 3'b000);
    chk("arst_en64", {bus64.bits_xor_en, bus64.bits_or_en, bus64.bits_and_en}, 3'b000);
    chk("arst_in_ready", {bus32.in_ready, bus64.in_ready}, 2'b11);
    q.delete();
    in_valid = 1'b0; wb_ready = 1'b1;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 32'h0020F1B3; rs1 = 64'hF0F0F0F0; rs2 = 64'h0FF00FF0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_data", bus32.wb_data, 32'h00F000F0);

    for (int i = 0; i < 60; i++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      in_instr = rand_instr();
      rs1 = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      wb_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
